// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC and runs the instruction-memory
// request/ack handshake, presenting one valid slot per fetch.
module pc_fetch_ctrl #(
   parameter int              PC_W       = 6,
   parameter logic [PC_W-1:0] START_ADDR = '0
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            start_i,
   input  logic            stall_i,
   input  logic            halt_i,
   input  logic            redirect_i,
   input  logic [PC_W-1:0] redirect_addr_i,
   output logic            imem_req_o,
   output logic [PC_W-1:0] imem_addr_o,
   input  logic            imem_ack_i,
   output logic [PC_W-1:0] pco_o,
   output logic            instr_valid_o,
   output logic            wrap_o,
   output logic            busy_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_HALTED
   } state_t;

   localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            pend_q, pend_d;
   logic [PC_W-1:0] pend_addr_q, pend_addr_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         pc_q        <= START_ADDR;
         pend_q      <= 1'b0;
         pend_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         pend_q      <= pend_d;
         pend_addr_q <= pend_addr_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      pend_d      = pend_q;
      pend_addr_d = pend_addr_q;
      wrap_o      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start_i) state_d = S_FETCH;
         end
         S_FETCH: begin
            if (imem_ack_i) begin
               pend_d = 1'b0;
               // a same-cycle redirect is newer than any pending one
               if (redirect_i) pc_d = redirect_addr_i;
               else if (pend_q) pc_d = pend_addr_q;
               else state_d = S_ISSUE;
            end else if (redirect_i) begin
               pend_d      = 1'b1;
               pend_addr_d = redirect_addr_i;
            end
         end
         S_ISSUE: begin
            if (halt_i) begin
               state_d = S_HALTED;
            end else if (stall_i) begin
               state_d = S_ISSUE;
            end else if (redirect_i) begin
               pc_d    = redirect_addr_i;
               state_d = S_FETCH;
            end else begin
               pc_d    = pc_q + PC_ONE;
               state_d = S_FETCH;
               wrap_o  = &pc_q;
            end
         end
         S_HALTED: begin
            if (start_i) state_d = S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign imem_req_o    = (state_q == S_FETCH);
   assign imem_addr_o   = pc_q;
   assign pco_o         = pc_q;
   assign instr_valid_o = (state_q == S_ISSUE);
   assign busy_o        = (state_q == S_FETCH) || (state_q == S_ISSUE);

endmodule
